// File: rtl/rpint_tx.sv
`default_nettype none
// ============================================================================
//  Module   : rpint_tx
//  Purpose  : RP interface link serial transmitter (initiator side). Each
//             accepted request is sent as one frame of AW address bits then
//             DW data bits, MSB first, on an sclk/mosi pair, followed by an
//             idle gap that marks the frame boundary for the receiver.
//  Ports    : clk      - system clock (pixel clock domain)
//             resetn   - asynchronous active-low reset
//             in_valid - frame request
//             in_ready - high while idle; a frame is accepted on a clk edge
//                        where in_valid and in_ready are both high
//             in_addr  - register address field (AW bits)
//             in_data  - data field (DW bits)
//             busy     - frame or trailing gap in progress (= !in_ready)
//             sclk     - serial clock, idle low, half-period DIV clk cycles
//             mosi     - serial data, changes only while sclk is low
//  Revision : 1.0 - initial release
// ============================================================================
module rpint_tx #(
  parameter int DIV = 4,   // clk cycles per sclk half-period (1..255)
  parameter int GAP = 16,  // idle clk cycles after each frame (1..65535)
  parameter int AW  = 8,   // address field width
  parameter int DW  = 32   // data field width
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          busy,
  output logic          sclk,
  output logic          mosi
);

  localparam int FW  = AW + DW;
  localparam int BCW = $clog2(FW);
  // Counters run 0..N-1; keep at least one bit so DIV=1 / GAP=1 stay legal.
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BCW-1:0] LAST_BIT = BCW'(FW - 1);
  localparam logic [DCW-1:0] LAST_DIV = DCW'(DIV - 1);
  localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    shift_q, shift_d;
  logic [BCW-1:0]   bit_q,   bit_d;
  logic [DCW-1:0]   div_q,   div_d;
  logic [GCW-1:0]   gap_q,   gap_d;
  logic             sclk_q,  sclk_d;
  logic             mosi_q,  mosi_d;
  logic [FW-1:0]    frame_w;

  assign frame_w = {in_addr, in_data};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  // sclk/mosi are computed one cycle ahead, alongside the next state, so the
  // pins come straight from flops and always agree with state_q.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d = frame_w;
          bit_d   = '0;
          div_d   = '0;
          state_d = S_LOW;
          mosi_d  = frame_w[FW-1];
        end
      end
      S_LOW: begin
        mosi_d = shift_q[FW-1];
        if (div_q == LAST_DIV) begin
          div_d   = '0;
          state_d = S_HIGH;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        mosi_d = shift_q[FW-1];
        sclk_d = 1'b1;
        if (div_q == LAST_DIV) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q < LAST_BIT) begin
            // Present the next bit as sclk falls; it is stable for the
            // whole low phase before the receiver's rising-edge sample.
            shift_d = shift_q << 1;
            bit_d   = bit_q + 1'b1;
            state_d = S_LOW;
            mosi_d  = shift_q[FW-2];
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
            mosi_d  = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = ~in_ready;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_rpint_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rpint_tx
//  Purpose  : Self-checking bench for rpint_tx. Two instances (DIV=2/GAP=8
//             and DIV=1/GAP=1) share one stimulus port through a selector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rpint_tx;

  localparam int DIV_A = 2, GAP_A = 8;
  localparam int DIV_B = 1, GAP_B = 1;
  localparam int FBITS = 40;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        sel;
  logic [7:0]  in_addr;
  logic [31:0] in_data;

  logic val_a, rdy_a, busy_a, sclk_a, mosi_a;
  logic val_b, rdy_b, busy_b, sclk_b, mosi_b;
  logic rdy, bsy, sck, sdo;

  assign val_a = in_valid & ~sel;
  assign val_b = in_valid &  sel;
  assign rdy   = sel ? rdy_b  : rdy_a;
  assign bsy   = sel ? busy_b : busy_a;
  assign sck   = sel ? sclk_b : sclk_a;
  assign sdo   = sel ? mosi_b : mosi_a;

  rpint_tx #(.DIV(DIV_A), .GAP(GAP_A), .AW(8), .DW(32)) dut_a (
    .clk(clk), .resetn(rstn), .in_valid(val_a), .in_ready(rdy_a),
    .in_addr(in_addr), .in_data(in_data), .busy(busy_a),
    .sclk(sclk_a), .mosi(mosi_a));

  rpint_tx #(.DIV(DIV_B), .GAP(GAP_B), .AW(8), .DW(32)) dut_b (
    .clk(clk), .resetn(rstn), .in_valid(val_b), .in_ready(rdy_b),
    .in_addr(in_addr), .in_data(in_data), .busy(busy_b),
    .sclk(sclk_b), .mosi(mosi_b));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference timing: a frame is 40 bits of 2*DIV cycles, then the gap.
  function automatic int exp_lat(input logic s);
    return s ? FBITS*2*DIV_B + GAP_B : FBITS*2*DIV_A + GAP_A;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", {79'd0, rdy}, 80'd1);
  endtask

  // Sends one frame (called at a negedge with rdy high) and records what a
  // receiver would see: mosi at each sclk rise, the rise count, cycles until
  // in_ready returns, and protocol violations (mosi moving while sclk high,
  // busy not the inverse of in_ready).
  task automatic send(input logic s, input logic [7:0] a, input logic [31:0] d,
                      input bit scr, output logic [39:0] got, output int edges,
                      output int lat, output int viol);
    int cnt;
    logic ps, pm;
    got = '0; edges = 0; viol = 0; cnt = 0; ps = 1'b0; pm = 1'b0;
    sel = s; in_addr = a; in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    do begin
      if (scr) begin
        in_valid = 1'($urandom_range(0, 1));
        in_addr  = 8'($urandom);
        in_data  = $urandom;
      end
      @(negedge clk);
      cnt++;
      if (sck && !ps) begin
        got = {got[38:0], sdo};
        edges++;
      end
      if (sck && ps && (sdo !== pm)) viol++;
      if (bsy !== ~rdy) viol++;
      ps = sck; pm = sdo;
    end while (!rdy && cnt < 4000);
    in_valid = 1'b0;
    lat = cnt - 1;
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [31:0] d;
    bit          scr;
    logic [39:0] ef;
    int          el;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] got;
    logic [79:0] got2;
    int edges, lat, viol, cnt, lowrun, gaprun, rdy_mid, highs;
    logic ps;

    vecs[0] = '{1'b0, 8'h00, 32'hA5A50F0F, 1'b0, 40'h00A5A50F0F, 168};
    vecs[1] = '{1'b0, 8'h00, 32'hFF00F000, 1'b0, 40'h00FF00F000, 168};
    vecs[2] = '{1'b0, 8'h3C, 32'h12345678, 1'b1, 40'h3C12345678, 168};
    vecs[3] = '{1'b1, 8'h81, 32'hDEADBEEF, 1'b0, 40'h81DEADBEEF, 81};
    vecs[4] = '{1'b1, 8'hFF, 32'h00000001, 1'b1, 40'hFF00000001, 81};
    for (int i = 5; i < 8; i++) begin
      vecs[i].s   = 1'(i % 2);
      vecs[i].a   = 8'($urandom);
      vecs[i].d   = $urandom;
      vecs[i].scr = 1'b1;
      vecs[i].ef  = {vecs[i].a, vecs[i].d};
      vecs[i].el  = exp_lat(vecs[i].s);
    end

    // Reset: outputs idle immediately, requests ignored while held.
    sel = 1'b0; in_valid = 1'b0; in_addr = 8'h00; in_data = 32'h0;
    rstn = 1'b0;
    #1;
    chk("rst_sclk_a", {79'd0, sclk_a}, 80'd0);
    chk("rst_ready_a", {79'd0, rdy_a}, 80'd1);
    in_valid = 1'b1; in_addr = 8'hAA; in_data = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    chk("rst_out_a", {76'd0, sclk_a, mosi_a, busy_a, rdy_a}, 80'd1);
    chk("rst_out_b", {76'd0, sclk_b, mosi_b, busy_b, rdy_b}, 80'd1);
    in_valid = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {78'd0, busy_a, rdy_a}, 80'd1);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].s;
      #1;
      wait_ready();
      send(vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].scr, got, edges, lat, viol);
      chk($sformatf("v%0d_frame", i), {40'd0, got}, {40'd0, vecs[i].ef});
      chk($sformatf("v%0d_edges", i), 80'(edges), 80'(FBITS));
      chk($sformatf("v%0d_latency", i), 80'(lat), 80'(vecs[i].el));
      chk($sformatf("v%0d_protocol", i), 80'(viol), 80'd0);
    end

    // Back-to-back: in_valid held high, second word presented while busy.
    sel = 1'b0;
    #1;
    wait_ready();
    in_addr = 8'h11; in_data = 32'h22334455; in_valid = 1'b1;
    @(posedge clk); #1;
    in_addr = 8'h99; in_data = 32'hCAFEF00D;
    got2 = '0; edges = 0; cnt = 0; lowrun = 0; gaprun = -1; rdy_mid = 0; ps = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (sck && !ps) begin
        if (edges == FBITS) gaprun = lowrun;
        got2 = {got2[78:0], sdo};
        edges++;
        lowrun = 0;
        if (edges == 2*FBITS) in_valid = 1'b0;
      end else if (!sck) begin
        lowrun++;
      end
      if (edges == FBITS && rdy) rdy_mid++;
      ps = sck;
    end while (!(edges >= 2*FBITS && rdy) && cnt < 8000);
    in_valid = 1'b0;
    chk("b2b_words", got2, {8'h11, 32'h22334455, 8'h99, 32'hCAFEF00D});
    chk("b2b_edges", 80'(edges), 80'(2*FBITS));
    chk("b2b_low_run", 80'(gaprun), 80'(GAP_A + 1 + DIV_A));
    chk("b2b_idle_cycles", 80'(rdy_mid), 80'd1);

    // Reset mid-frame while sclk and mosi are both high.
    @(negedge clk);
    wait_ready();
    in_addr = 8'hFF; in_data = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0; cnt = 0; ps = 1'b0;
    while (edges < 18 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (sck && !ps) edges++;
      ps = sck;
    end
    chk("abort_pre_high", {78'd0, sclk_a, mosi_a}, 80'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_pins", {78'd0, sclk_a, mosi_a}, 80'd0);
    chk("abort_ready", {78'd0, busy_a, rdy_a}, 80'd1);
    highs = 0;
    repeat (3) begin
      @(negedge clk);
      if (sclk_a || mosi_a) highs++;
    end
    chk("abort_quiet", 80'(highs), 80'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", {79'd0, rdy_a}, 80'd1);
    send(1'b0, 8'h5A, 32'h0F1E2D3C, 1'b0, got, edges, lat, viol);
    chk("after_abort_frame", {40'd0, got}, {40'd0, 8'h5A, 32'h0F1E2D3C});
    chk("after_abort_edges", 80'(edges), 80'(FBITS));
    chk("after_abort_latency", 80'(lat), 80'(exp_lat(1'b0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
